// File: rtl/stream_classifier_mac.sv
// Streaming linear classifier: per-beat multiply-accumulate of feature lanes against
// a synchronous weight ROM, per-class bias, then sequential argmax with top-2 margin.
//
// state    | meaning
// S_IDLE   | waiting for start; previous result outputs held
// S_LOAD   | accepting feature beats, accumulating one cycle behind the handshake
// S_DRAIN  | accumulate the final registered beat
// S_BIAS   | add per-class bias with saturation, seed the argmax
// S_ARGMAX | compare one class per cycle (classes 1..NUM_CLASSES-1)
// S_OUT    | first cycle latches results, then hold result_valid until result_ready
module stream_classifier_mac #(
    parameter int NUM_CLASSES     = 4,
    parameter int NUM_CELLS       = 1024,
    parameter int PARALLEL_INPUTS = 4,
    parameter int VALUE_BITS      = 6,
    parameter int FEATURE_SIGNED  = 0,
    parameter int WEIGHT_BITS     = 8,
    parameter int BIAS_BITS       = 16,
    parameter int ACC_BITS        = 24,
    parameter int CLS_BITS        = $clog2(NUM_CLASSES),
    parameter int ADDR_BITS       = $clog2(NUM_CELLS)
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               start,
    output logic                                               busy,
    input  logic [PARALLEL_INPUTS*VALUE_BITS-1:0]              feature_in,
    input  logic                                               feature_valid,
    output logic                                               feature_ready,
    output logic [PARALLEL_INPUTS*ADDR_BITS-1:0]               w_addr_flat,
    input  logic [PARALLEL_INPUTS*NUM_CLASSES*WEIGHT_BITS-1:0] w_data_flat,
    input  logic [NUM_CLASSES*BIAS_BITS-1:0]                   bias_flat,
    output logic                                               result_valid,
    input  logic                                               result_ready,
    output logic [CLS_BITS-1:0]                                best_class,
    output logic [ACC_BITS-1:0]                                margin,
    output logic [NUM_CLASSES*ACC_BITS-1:0]                    scores_flat,
    output logic                                               sat_flag
);

    localparam int NUM_BEATS = (NUM_CELLS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS;
    localparam int BEAT_BITS = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int WIDE      = ACC_BITS + BIAS_BITS + VALUE_BITS + WEIGHT_BITS + 6;
    localparam logic FSIGN   = (FEATURE_SIGNED != 0);

    localparam logic signed [ACC_BITS-1:0] ACC_MAX  = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN  = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [WIDE-1:0]     WIDE_MAX = {{(WIDE-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [WIDE-1:0]     WIDE_MIN = {{(WIDE-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_BIAS   = 3'd3;
    localparam logic [2:0] S_ARGMAX = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]                            state;
    logic [BEAT_BITS-1:0]                  beat_cnt;
    logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feat_q;
    logic [PARALLEL_INPUTS-1:0]            mask_q;
    logic [PARALLEL_INPUTS-1:0]            lane_mask;
    logic                                  acc_en_q;
    logic signed [ACC_BITS-1:0]            acc       [NUM_CLASSES];
    logic signed [ACC_BITS-1:0]            acc_next  [NUM_CLASSES];
    logic signed [ACC_BITS-1:0]            bias_next [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]                acc_clip;
    logic [NUM_CLASSES-1:0]                bias_clip;
    logic [CLS_BITS-1:0]                   cls_idx;
    logic [CLS_BITS-1:0]                   best_idx;
    logic signed [ACC_BITS-1:0]            best_val;
    logic signed [ACC_BITS-1:0]            second_val;
    logic signed [ACC_BITS:0]              margin_diff;
    logic [ACC_BITS-1:0]                   margin_val;
    logic signed [WIDE-1:0]                lane_sum;
    logic signed [WIDE-1:0]                fx;
    logic signed [WIDE-1:0]                wx;
    logic signed [WIDE-1:0]                acc_ext;
    logic signed [WIDE-1:0]                bias_ext;
    logic [VALUE_BITS-1:0]                 f_lane;
    logic [WEIGHT_BITS-1:0]                w_lane;
    int                                    idx;

    // Returns {clipped, value} after clamping a wide sum into the signed score range.
    function automatic logic [ACC_BITS:0] sat_wide(input logic signed [WIDE-1:0] v);
        if (v > WIDE_MAX)
            return {1'b1, ACC_MAX};
        else if (v < WIDE_MIN)
            return {1'b1, ACC_MIN};
        else
            return {1'b0, v[ACC_BITS-1:0]};
    endfunction

    assign busy          = (state != S_IDLE);
    assign feature_ready = (state == S_LOAD);

    // Lanes past the end of the frame read address 0 and are masked out.
    always_comb begin
        w_addr_flat = '0;
        lane_mask   = '0;
        idx         = 0;
        for (int p = 0; p < PARALLEL_INPUTS; p++) begin
            idx = int'(beat_cnt) * PARALLEL_INPUTS + p;
            if (idx < NUM_CELLS) begin
                w_addr_flat[p*ADDR_BITS +: ADDR_BITS] = idx[ADDR_BITS-1:0];
                lane_mask[p] = 1'b1;
            end
        end
    end

    always_comb begin
        lane_sum  = '0;
        fx        = '0;
        wx        = '0;
        acc_ext   = '0;
        bias_ext  = '0;
        f_lane    = '0;
        w_lane    = '0;
        acc_clip  = '0;
        bias_clip = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            lane_sum = '0;
            for (int p = 0; p < PARALLEL_INPUTS; p++) begin
                f_lane = feat_q[p*VALUE_BITS +: VALUE_BITS];
                w_lane = w_data_flat[(p*NUM_CLASSES+k)*WEIGHT_BITS +: WEIGHT_BITS];
                fx = {{(WIDE-VALUE_BITS){FSIGN & f_lane[VALUE_BITS-1]}}, f_lane};
                wx = {{(WIDE-WEIGHT_BITS){w_lane[WEIGHT_BITS-1]}}, w_lane};
                if (mask_q[p])
                    lane_sum = lane_sum + fx * wx;
            end
            acc_ext  = {{(WIDE-ACC_BITS){acc[k][ACC_BITS-1]}}, acc[k]};
            bias_ext = {{(WIDE-BIAS_BITS){bias_flat[k*BIAS_BITS+BIAS_BITS-1]}},
                        bias_flat[k*BIAS_BITS +: BIAS_BITS]};
            {acc_clip[k], acc_next[k]}   = sat_wide(acc_ext + lane_sum);
            {bias_clip[k], bias_next[k]} = sat_wide(acc_ext + bias_ext);
        end
    end

    // best >= second always holds, so only the positive overflow needs clamping.
    assign margin_diff = {best_val[ACC_BITS-1], best_val} - {second_val[ACC_BITS-1], second_val};
    assign margin_val  = (margin_diff > $signed({1'b0, ACC_MAX})) ? ACC_MAX : margin_diff[ACC_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            feat_q       <= '0;
            mask_q       <= '0;
            acc_en_q     <= 1'b0;
            sat_flag     <= 1'b0;
            cls_idx      <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            second_val   <= '0;
            result_valid <= 1'b0;
            best_class   <= '0;
            margin       <= '0;
            scores_flat  <= '0;
            for (int k = 0; k < NUM_CLASSES; k++)
                acc[k] <= '0;
        end else begin
            acc_en_q <= 1'b0;
            if (acc_en_q) begin
                for (int k = 0; k < NUM_CLASSES; k++)
                    acc[k] <= acc_next[k];
                if (|acc_clip)
                    sat_flag <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        beat_cnt <= '0;
                        sat_flag <= 1'b0;
                        for (int k = 0; k < NUM_CLASSES; k++)
                            acc[k] <= '0;
                    end
                end
                S_LOAD: begin
                    if (feature_valid) begin
                        feat_q   <= feature_in;
                        mask_q   <= lane_mask;
                        acc_en_q <= 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_BITS'(NUM_BEATS-1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: state <= S_BIAS;
                S_BIAS: begin
                    for (int k = 0; k < NUM_CLASSES; k++)
                        acc[k] <= bias_next[k];
                    if (|bias_clip)
                        sat_flag <= 1'b1;
                    best_val   <= bias_next[0];
                    best_idx   <= '0;
                    second_val <= ACC_MIN;
                    cls_idx    <= CLS_BITS'(1);
                    state      <= S_ARGMAX;
                end
                S_ARGMAX: begin
                    if (acc[cls_idx] > best_val) begin
                        second_val <= best_val;
                        best_val   <= acc[cls_idx];
                        best_idx   <= cls_idx;
                    end else if (acc[cls_idx] > second_val) begin
                        second_val <= acc[cls_idx];
                    end
                    if (cls_idx == CLS_BITS'(NUM_CLASSES-1))
                        state <= S_OUT;
                    else
                        cls_idx <= cls_idx + 1'b1;
                end
                S_OUT: begin
                    if (!result_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++)
                            scores_flat[k*ACC_BITS +: ACC_BITS] <= acc[k];
                        best_class   <= best_idx;
                        margin       <= margin_val;
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_classifier_mac.sv
// Directed bench: instance A (8 cells, 4 classes, unsigned, 12-bit scores) and
// instance B (10 cells, 5 classes, signed features, ragged final beat).
module tb_stream_classifier_mac;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // instance A
    logic         a_start, a_busy, a_fv, a_fr, a_rv, a_rr, a_sat;
    logic [23:0]  a_feat;
    logic [11:0]  a_waddr;
    logic [127:0] a_wdata;
    logic [63:0]  a_bias;
    logic [1:0]   a_best;
    logic [11:0]  a_margin;
    logic [47:0]  a_scores;
    logic [7:0]   wa [8][4];
    logic [5:0]   fa [8];

    // instance B
    logic         b_start, b_busy, b_fv, b_fr, b_rv, b_rr, b_sat;
    logic [23:0]  b_feat;
    logic [15:0]  b_waddr;
    logic [159:0] b_wdata;
    logic [79:0]  b_bias;
    logic [2:0]   b_best;
    logic [23:0]  b_margin;
    logic [119:0] b_scores;
    logic [7:0]   wb [10][5];
    logic [5:0]   fb [10];

    stream_classifier_mac #(
        .NUM_CLASSES(4), .NUM_CELLS(8), .PARALLEL_INPUTS(4), .VALUE_BITS(6),
        .FEATURE_SIGNED(0), .WEIGHT_BITS(8), .BIAS_BITS(16), .ACC_BITS(12)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy),
        .feature_in(a_feat), .feature_valid(a_fv), .feature_ready(a_fr),
        .w_addr_flat(a_waddr), .w_data_flat(a_wdata), .bias_flat(a_bias),
        .result_valid(a_rv), .result_ready(a_rr), .best_class(a_best),
        .margin(a_margin), .scores_flat(a_scores), .sat_flag(a_sat)
    );

    stream_classifier_mac #(
        .NUM_CLASSES(5), .NUM_CELLS(10), .PARALLEL_INPUTS(4), .VALUE_BITS(6),
        .FEATURE_SIGNED(1), .WEIGHT_BITS(8), .BIAS_BITS(16), .ACC_BITS(24)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy),
        .feature_in(b_feat), .feature_valid(b_fv), .feature_ready(b_fr),
        .w_addr_flat(b_waddr), .w_data_flat(b_wdata), .bias_flat(b_bias),
        .result_valid(b_rv), .result_ready(b_rr), .best_class(b_best),
        .margin(b_margin), .scores_flat(b_scores), .sat_flag(b_sat)
    );

    // Synchronous weight ROMs, one cycle of read latency.
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++)
                a_wdata[(p*4+k)*8 +: 8] <= wa[a_waddr[p*3 +: 3]][k];
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 5; k++)
                b_wdata[(p*5+k)*8 +: 8] <= (b_waddr[p*4 +: 4] < 4'd10) ? wb[b_waddr[p*4 +: 4]][k] : 8'h00;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_a();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("a_busy_after_start", a_busy, 1);
    endtask

    task automatic start_b();
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        chk("b_busy_after_start", b_busy, 1);
    endtask

    task automatic send_a(input int g0, input int g1);
        int gaps[2];
        int t;
        gaps[0] = g0;
        gaps[1] = g1;
        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                @(negedge clk); a_fv = 1'b0; a_feat = '1;
            end
            @(negedge clk);
            a_fv = 1'b1;
            for (int p = 0; p < 4; p++) a_feat[p*6 +: 6] = fa[b*4+p];
            t = 0;
            while (a_fr !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            chk("a_feature_ready", a_fr, 1);
        end
    endtask

    task automatic send_b(input int g0, input int g1, input int g2);
        int gaps[3];
        int t;
        gaps[0] = g0;
        gaps[1] = g1;
        gaps[2] = g2;
        for (int b = 0; b < 3; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                @(negedge clk); b_fv = 1'b0; b_feat = '1;
            end
            @(negedge clk);
            b_fv = 1'b1;
            for (int p = 0; p < 4; p++) begin
                if (b*4+p < 10) b_feat[p*6 +: 6] = fb[b*4+p];
                else            b_feat[p*6 +: 6] = 6'h2A;
            end
            t = 0;
            while (b_fr !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            chk("b_feature_ready", b_fr, 1);
            if (b == 0) chk("b_waddr_beat0", b_waddr, 16'h3210);
            if (b == 2) chk("b_waddr_ragged", b_waddr, 16'h0098);
        end
    endtask

    // Counts cycles from the last handshake cycle to the first cycle with result_valid high.
    task automatic wait_a(input int lat);
        int n;
        n = 1;
        @(negedge clk); a_fv = 1'b0;
        chk("a_ready_after_last", a_fr, 0);
        while (a_rv !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("a_latency", n, lat);
    endtask

    task automatic wait_b(input int lat);
        int n;
        n = 1;
        @(negedge clk); b_fv = 1'b0;
        chk("b_ready_after_3_beats", b_fr, 0);
        while (b_rv !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("b_latency", n, lat);
    endtask

    task automatic accept_a();
        @(negedge clk); a_rr = 1'b1;
        @(negedge clk); a_rr = 1'b0;
        chk("a_rv_after_accept", a_rv, 0);
        chk("a_busy_after_accept", a_busy, 0);
    endtask

    task automatic accept_b();
        @(negedge clk); b_rr = 1'b1;
        @(negedge clk); b_rr = 1'b0;
        chk("b_rv_after_accept", b_rv, 0);
        chk("b_busy_after_accept", b_busy, 0);
    endtask

    task automatic res_a(input logic [47:0] sc, input int best, input int mg, input int sat);
        chk("a_scores", a_scores, sc);
        chk("a_best_class", a_best, best);
        chk("a_margin", a_margin, mg);
        chk("a_sat_flag", a_sat, sat);
    endtask

    task automatic res_b(input logic [119:0] sc, input int best, input int mg, input int sat);
        chk("b_scores", b_scores, sc);
        chk("b_best_class", b_best, best);
        chk("b_margin", b_margin, mg);
        chk("b_sat_flag", b_sat, sat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_start = 0; a_fv = 0; a_rr = 0; a_feat = '0; a_bias = '0;
        b_start = 0; b_fv = 0; b_rr = 0; b_feat = '0; b_bias = '0;
        for (int c = 0; c < 8; c++) begin
            fa[c] = 6'd1;
            for (int k = 0; k < 4; k++) wa[c][k] = 8'(k + 1);
        end
        for (int c = 0; c < 10; c++) begin
            fb[c] = 6'h3F;
            wb[c][0] = 8'd3;
            wb[c][1] = 8'd0;
            wb[c][2] = 8'(c);
            wb[c][3] = 8'hFE;
            wb[c][4] = 8'd1;
        end
        repeat (3) @(negedge clk);

        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_ready", a_fr, 0);
        chk("rst_a_rv", a_rv, 0);
        chk("rst_a_scores", a_scores, 0);
        chk("rst_a_best", a_best, 0);
        chk("rst_a_margin", a_margin, 0);
        chk("rst_a_sat", a_sat, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_rv", b_rv, 0);
        rst_n = 1'b1;

        // ramp weights: scores 8,16,24,32
        chk("a_rr_while_idle_ignored", a_busy, 0);
        start_a();
        send_a(0, 0);
        wait_a(7);
        res_a({12'd32, 12'd24, 12'd16, 12'd8}, 3, 8, 0);
        accept_a();

        // gaps 1,0,0,1 pattern; then hold result under back-pressure with start pulses
        start_a();
        send_a(0, 2);
        wait_a(7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_start = (i % 2 == 0);
            chk("a_hold_rv", a_rv, 1);
            chk("a_hold_scores", a_scores, {12'd32, 12'd24, 12'd16, 12'd8});
            chk("a_hold_best", a_best, 3);
        end
        a_start = 1'b0;
        res_a({12'd32, 12'd24, 12'd16, 12'd8}, 3, 8, 0);
        accept_a();
        @(negedge clk);
        chk("a_start_during_out_ignored", a_busy, 0);

        // saturation at 2047
        for (int c = 0; c < 8; c++) begin
            fa[c] = 6'd63;
            for (int k = 0; k < 4; k++) wa[c][k] = 8'd127;
        end
        start_a();
        send_a(0, 0);
        wait_a(7);
        res_a({12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF}, 0, 0, 1);
        accept_a();

        // ties via bias only: 5,9,9,2
        for (int c = 0; c < 8; c++) fa[c] = 6'd0;
        a_bias = {16'd2, 16'd9, 16'd9, 16'd5};
        start_a();
        chk("a_prev_scores_held", a_scores, {12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF});
        chk("a_sat_cleared_on_start", a_sat, 0);
        send_a(1, 0);
        wait_a(7);
        res_a({12'd2, 12'd9, 12'd9, 12'd5}, 1, 0, 0);
        accept_a();

        // reset in the middle of S_LOAD
        a_bias = '0;
        for (int c = 0; c < 8; c++) begin
            fa[c] = 6'd1;
            for (int k = 0; k < 4; k++) wa[c][k] = 8'(k + 1);
        end
        start_a();
        @(negedge clk);
        a_fv = 1'b1;
        for (int p = 0; p < 4; p++) a_feat[p*6 +: 6] = fa[p];
        @(negedge clk);
        a_fv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", a_busy, 0);
        chk("midrst_ready", a_fr, 0);
        chk("midrst_rv", a_rv, 0);
        chk("midrst_scores", a_scores, 0);
        chk("midrst_best", a_best, 0);
        chk("midrst_sat", a_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_a();
        send_a(0, 0);
        wait_a(7);
        res_a({12'd32, 12'd24, 12'd16, 12'd8}, 3, 8, 0);
        accept_a();

        // ragged, signed: scores 70,0,5,15,2
        b_bias = {16'd12, 16'hFFFB, 16'd50, 16'd0, 16'd100};
        start_b();
        send_b(0, 0, 0);
        wait_b(8);
        res_b({24'd2, 24'd15, 24'd5, 24'd0, 24'd70}, 0, 55, 0);
        accept_b();

        // single feature -1 on cell 4 with gaps: scores -3,0,-4,2,-1
        b_bias = '0;
        for (int c = 0; c < 10; c++) fb[c] = 6'd0;
        fb[4] = 6'h3F;
        start_b();
        send_b(1, 0, 2);
        wait_b(8);
        res_b({24'hFFFFFF, 24'd2, 24'hFFFFFC, 24'd0, 24'hFFFFFD}, 3, 2, 0);
        accept_b();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_classifier_mac.md
Name: stream_classifier_mac

Overview:
Next-generation linear classifier for the voxel-bin path. It streams PARALLEL_INPUTS feature values per beat against a synchronous weight ROM and accumulates one score per class. It saturates, adds per-class bias, then runs a sequential argmax that also reports the top-2 margin. Results are held on a valid/ready handshake toward the gesture output logic. Arbitrary class counts, signed or unsigned features, ragged final beats and back-pressure on both sides are supported.

Parameters:
NUM_CLASSES, 4, number of output classes (2..64)
NUM_CELLS, 1024, features per frame
PARALLEL_INPUTS, 4, feature lanes per beat (1..16); NUM_CELLS need not be a multiple
VALUE_BITS, 6, feature width per lane
FEATURE_SIGNED, 0, 1: features two's-complement; 0: zero-extended
WEIGHT_BITS, 8, signed weight width
BIAS_BITS, 16, signed per-class bias width
ACC_BITS, 24, signed accumulator/score width
CLS_BITS, $clog2(NUM_CLASSES), class index width (derived)
ADDR_BITS, $clog2(NUM_CELLS), weight address width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active low
start  in  1  begin frame; ignored unless busy=0
busy  out  1  high from accepted start until result handshake completes
feature_in  in  PARALLEL_INPUTS*VALUE_BITS  lane p at [p*VALUE_BITS +: VALUE_BITS]
feature_valid  in  1  beat offered
feature_ready  out  1  beat accepted when valid&ready
w_addr_flat  out  PARALLEL_INPUTS*ADDR_BITS  per-lane cell address, combinational from beat counter
w_data_flat  in  PARALLEL_INPUTS*NUM_CLASSES*WEIGHT_BITS  ROM data, 1 cycle after address; lane p class k at [(p*NUM_CLASSES+k)*WEIGHT_BITS +: WEIGHT_BITS]
bias_flat  in  NUM_CLASSES*BIAS_BITS  static per-class bias, sampled in S_BIAS
result_valid  out  1  result held until result_ready
result_ready  in  1  consumer accept
best_class  out  CLS_BITS  argmax index
margin  out  ACC_BITS  best minus second-best score, >=0, saturated
scores_flat  out  NUM_CLASSES*ACC_BITS  final per-class scores
sat_flag  out  1  any accumulator saturated this frame

Behaviour:
- Reset: state S_IDLE; busy, feature_ready, result_valid, sat_flag = 0; best_class, margin, scores_flat, accumulators, counters = 0. Reset mid-frame aborts immediately; no partial result is emitted.
- States: S_IDLE -> (start) S_LOAD -> (last beat accepted) S_DRAIN -> S_BIAS -> S_ARGMAX (NUM_CLASSES-1 cycles) -> S_OUT -> (result_ready) S_IDLE.
- S_IDLE: on start, clear accumulators, beat_cnt and sat_flag; go to S_LOAD. Previous scores_flat, best_class and margin are held until S_OUT of the new frame.
- S_LOAD: feature_ready=1. w_addr lane p = beat_cnt*PARALLEL_INPUTS+p, or 0 if that index >= NUM_CELLS. On handshake, register features plus a lane mask; beat_cnt++. Last beat is beat_cnt = ceil(NUM_CELLS/PARALLEL_INPUTS)-1. Gaps in feature_valid are allowed; a stall adds no accumulation.
- Accumulate stage: one cycle after handshake, aligned with ROM data. Per class, sum over unmasked lanes of feature (sign- or zero-extended to VALUE_BITS+1) times signed weight. Add the lane sum to the accumulator with saturation to ACC_BITS signed min/max. Any clip sets sat_flag (sticky for the frame). Masked lanes contribute 0.
- S_DRAIN: 1 cycle; the final registered beat is accumulated; feature_ready=0.
- S_BIAS: 1 cycle; add sign-extended bias to every accumulator with saturation; clips set sat_flag.
- S_ARGMAX: init best=acc[0], second=most-negative. Each cycle compares one class i=1..N-1. If acc[i] > best, then second<=best and best<=acc[i]; else if acc[i] > second, then second<=acc[i]. Ties keep the lower index.
- S_OUT: entry cycle latches scores_flat, best_class and margin = sat(best-second); result_valid=1. result_valid and all result outputs stay stable until result_ready. Completion goes to S_IDLE; busy falls the same cycle.
- Latency: last beat handshake to result_valid = NUM_CLASSES+3 cycles.
- start while busy=1 is ignored. result_ready while result_valid=0 is ignored.

Test Plan:
- NUM_CELLS=8, P=4, N=4, all features 1, weights for class k = k+1, bias 0 -> scores 8,16,24,32; best_class=3; margin=8; sat_flag=0; result_valid 7 cycles after second beat.
- NUM_CELLS=10, P=4, N=5 (ragged last beat) -> lanes 2,3 of beat 2 contribute 0 even with nonzero data; w_addr for those lanes = 0; 3 beats accepted.
- feature_valid toggled 1,0,0,1 with random gaps -> scores identical to the gap-free run.
- Weights +127, features 63, ACC_BITS=12 -> score clamps at 2047; sat_flag=1.
- Equal scores 5,9,9,2 -> best_class=1, margin=0. FEATURE_SIGNED=1 with feature -1 and weight 3 -> contribution -3.
- result_ready held low 20 cycles -> outputs stable and start ignored. Assert rst_n=0 mid S_LOAD -> all outputs 0 next edge; a fresh frame then completes correctly.
